// File: rtl/jtframe_dwnld_banker.sv
// ROM download router: packs ioctl bytes into 16-bit SDRAM words,
// splits the image across up to four banks and diverts a PROM tail.
module jtframe_dwnld_banker #(
    parameter int          SDRAMW     = 22,
    parameter int          BANKS      = 4,
    parameter logic [25:0] BA1_START  = 26'h100000,
    parameter logic [25:0] BA2_START  = 26'h200000,
    parameter logic [25:0] BA3_START  = 26'h300000,
    parameter logic [25:0] PROM_START = 26'h3FFFFFF,
    parameter bit          SWAB       = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ioctl_rom,
    input  logic [25:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              prom_we,
    output logic              dwnld_busy,
    output logic              overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]        state;
    logic              rom_q;

    logic              in_prom;
    logic              in_odd;
    logic [1:0]        in_ba;
    logic [25:0]       in_base;
    logic [SDRAMW-1:0] in_addr;
    logic [SDRAMW-1:0] prom_off;

    logic              hold_valid, hold_odd;
    logic [1:0]        hold_ba;
    logic [SDRAMW-1:0] hold_addr;
    logic [7:0]        hold_byte;

    logic              slot_we;
    logic [SDRAMW-1:0] slot_addr;
    logic [15:0]       slot_data;
    logic [1:0]        slot_mask, slot_ba;

    logic              p1_v, prom_q;
    logic [SDRAMW-1:0] p1_addr, prom_addr;
    logic [7:0]        p1_byte, prom_byte;

    logic              n_hv, n_hodd;
    logic [1:0]        n_hba;
    logic [SDRAMW-1:0] n_haddr;
    logic [7:0]        n_hbyte;
    logic              n_we;
    logic [SDRAMW-1:0] n_addr;
    logic [15:0]       n_data;
    logic [1:0]        n_mask, n_ba;
    logic              n_ovf;

    logic slot_free, sd_wr, pair, flushable, rom_rise;

    function automatic logic [1:0] lane_mask(input logic odd);
        return (odd ^ SWAB) ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        in_prom = ioctl_addr >= PROM_START;
        in_odd  = ioctl_addr[0];
        in_ba   = 2'd0;
        in_base = 26'd0;
        if (BANKS >= 4 && ioctl_addr >= BA3_START) begin
            in_ba   = 2'd3;
            in_base = BA3_START;
        end else if (BANKS >= 3 && ioctl_addr >= BA2_START) begin
            in_ba   = 2'd2;
            in_base = BA2_START;
        end else if (BANKS >= 2 && ioctl_addr >= BA1_START) begin
            in_ba   = 2'd1;
            in_base = BA1_START;
        end
        in_addr  = SDRAMW'((ioctl_addr - in_base) >> 1);
        prom_off = SDRAMW'(ioctl_addr - PROM_START);
    end

    assign slot_free = (state != WRITE) || prog_rdy;
    assign sd_wr     = ioctl_wr && !in_prom;
    assign rom_rise  = ioctl_rom && !rom_q;
    assign pair      = hold_valid && !hold_odd && in_odd &&
                       in_ba == hold_ba && in_addr == hold_addr;
    // an even byte keeps waiting for its partner while the download runs
    assign flushable = hold_odd || !ioctl_rom;

    always_comb begin
        n_hv    = hold_valid;
        n_hodd  = hold_odd;
        n_hba   = hold_ba;
        n_haddr = hold_addr;
        n_hbyte = hold_byte;
        n_we    = slot_we;
        n_addr  = slot_addr;
        n_data  = slot_data;
        n_mask  = slot_mask;
        n_ba    = slot_ba;
        n_ovf   = overflow && !rom_rise;
        if (state == WRITE && prog_rdy) n_we = 1'b0;
        if (sd_wr) begin
            if (hold_valid && !slot_free) begin
                n_ovf = 1'b1;
            end else if (pair) begin
                n_we   = 1'b1;
                n_addr = hold_addr;
                n_ba   = hold_ba;
                n_mask = 2'b00;
                n_data = SWAB ? {ioctl_dout, hold_byte}
                              : {hold_byte, ioctl_dout};
                n_hv   = 1'b0;
            end else if (hold_valid || !in_odd || !slot_free) begin
                if (hold_valid) begin
                    n_we   = 1'b1;
                    n_addr = hold_addr;
                    n_ba   = hold_ba;
                    n_mask = lane_mask(hold_odd);
                    n_data = {hold_byte, hold_byte};
                end
                n_hv    = 1'b1;
                n_hodd  = in_odd;
                n_hba   = in_ba;
                n_haddr = in_addr;
                n_hbyte = ioctl_dout;
            end else begin
                n_we   = 1'b1;
                n_addr = in_addr;
                n_ba   = in_ba;
                n_mask = lane_mask(1'b1);
                n_data = {ioctl_dout, ioctl_dout};
            end
        end else if (hold_valid && flushable && slot_free) begin
            n_we   = 1'b1;
            n_addr = hold_addr;
            n_ba   = hold_ba;
            n_mask = lane_mask(hold_odd);
            n_data = {hold_byte, hold_byte};
            n_hv   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_q      <= 1'b0;
            hold_valid <= 1'b0;
            hold_odd   <= 1'b0;
            hold_ba    <= 2'd0;
            hold_addr  <= '0;
            hold_byte  <= 8'd0;
            slot_we    <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= 16'd0;
            slot_mask  <= 2'b11;
            slot_ba    <= 2'd0;
            overflow   <= 1'b0;
            p1_v       <= 1'b0;
            p1_addr    <= '0;
            p1_byte    <= 8'd0;
            prom_q     <= 1'b0;
            prom_addr  <= '0;
            prom_byte  <= 8'd0;
        end else begin
            state      <= n_we ? WRITE : (n_hv ? HOLD : IDLE);
            rom_q      <= ioctl_rom;
            hold_valid <= n_hv;
            hold_odd   <= n_hodd;
            hold_ba    <= n_hba;
            hold_addr  <= n_haddr;
            hold_byte  <= n_hbyte;
            slot_we    <= n_we;
            slot_addr  <= n_addr;
            slot_data  <= n_data;
            slot_mask  <= n_mask;
            slot_ba    <= n_ba;
            overflow   <= n_ovf;
            p1_v       <= ioctl_wr && in_prom;
            p1_addr    <= prom_off;
            p1_byte    <= ioctl_dout;
            prom_q     <= p1_v;
            prom_addr  <= p1_addr;
            prom_byte  <= p1_byte;
        end
    end

    // the PROM strobe borrows the address/data bus for its single cycle
    assign prog_addr  = prom_q ? prom_addr : slot_addr;
    assign prog_data  = prom_q ? {prom_byte, prom_byte} : slot_data;
    assign prog_mask  = slot_mask;
    assign prog_ba    = slot_ba;
    assign prog_we    = slot_we;
    assign prom_we    = prom_q;
    assign dwnld_busy = ioctl_rom | hold_valid | slot_we;

endmodule

// File: tb/tb_jtframe_dwnld_banker.sv
// Directed bench for jtframe_dwnld_banker: a 4-bank/no-swap instance
// and a 1-bank/swapped instance driven by the same byte stream.
module tb_jtframe_dwnld_banker;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioctl_rom;
    logic [25:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        prog_rdy;

    logic [21:0] prog_addr, prog_addr1;
    logic [15:0] prog_data, prog_data1;
    logic [1:0]  prog_mask, prog_mask1;
    logic [1:0]  prog_ba, prog_ba1;
    logic        prog_we, prog_we1;
    logic        prom_we, prom_we1;
    logic        dwnld_busy, dwnld_busy1;
    logic        overflow, overflow1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtframe_dwnld_banker #(
        .BANKS(4), .SWAB(1'b0), .PROM_START(26'h380000)
    ) u0 (
        .clk(clk), .rst(rst), .ioctl_rom(ioctl_rom),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
        .prom_we(prom_we), .dwnld_busy(dwnld_busy),
        .overflow(overflow)
    );

    jtframe_dwnld_banker #(
        .BANKS(1), .SWAB(1'b1), .PROM_START(26'h380000)
    ) u1 (
        .clk(clk), .rst(rst), .ioctl_rom(ioctl_rom),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .prog_addr(prog_addr1),
        .prog_data(prog_data1), .prog_mask(prog_mask1),
        .prog_ba(prog_ba1), .prog_we(prog_we1), .prog_rdy(prog_rdy),
        .prom_we(prom_we1), .dwnld_busy(dwnld_busy1),
        .overflow(overflow1)
    );

    typedef struct {
        logic [25:0] a;
        logic [7:0]  e;
        logic [7:0]  o;
        logic [21:0] addr0;
        logic [1:0]  ba0;
        logic [21:0] addr1;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [25:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic rdy_pulse();
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ioctl_rom = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; prog_rdy = 1'b0;
        tbl[0] = '{26'h000000, 8'h11, 8'h22, 22'h000000, 2'd0, 22'h000000};
        tbl[1] = '{26'h100006, 8'h33, 8'h44, 22'h000003, 2'd1, 22'h080003};
        tbl[2] = '{26'h200010, 8'h55, 8'h66, 22'h000008, 2'd2, 22'h100008};
        tbl[3] = '{26'h302002, 8'h77, 8'h88, 22'h001001, 2'd3, 22'h181001};
        tbl[4] = '{26'h00FFFE, 8'h9A, 8'hBC, 22'h007FFF, 2'd0, 22'h007FFF};

        repeat (3) @(negedge clk);
        chk("rst_we", prog_we, 0);
        chk("rst_mask", prog_mask, 2'b11);
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_ba", prog_ba, 0);
        chk("rst_flags", {overflow, prom_we, dwnld_busy}, 0);

        rst = 1'b0; ioctl_rom = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].a, tbl[i].e);
            chk("pair_wait", prog_we, 0);
            send(tbl[i].a | 26'd1, tbl[i].o);
            chk("pair_we", prog_we, 1);
            chk("pair_addr", prog_addr, tbl[i].addr0);
            chk("pair_data", prog_data, {tbl[i].e, tbl[i].o});
            chk("pair_mask", prog_mask, 2'b00);
            chk("pair_ba", prog_ba, tbl[i].ba0);
            chk("swab_addr", prog_addr1, tbl[i].addr1);
            chk("swab_data", prog_data1, {tbl[i].o, tbl[i].e});
            chk("swab_ba", prog_ba1, 0);
            rdy_pulse();
            chk("pair_done", {prog_we, prog_we1}, 0);
        end

        send(26'h200005, 8'hAA);
        chk("odd_we", prog_we, 1);
        chk("odd_ba", prog_ba, 2);
        chk("odd_addr", prog_addr, 2);
        chk("odd_mask", prog_mask, 2'b10);
        chk("odd_data", prog_data, 16'hAAAA);
        ioctl_rom = 1'b0;
        @(negedge clk);
        chk("odd_busy", {prog_we, dwnld_busy}, 2'b11);
        rdy_pulse();
        chk("odd_idle", dwnld_busy, 0);

        ioctl_rom = 1'b1;
        @(negedge clk);
        send(26'h100008, 8'hBB);
        chk("even_wait", {prog_we, dwnld_busy}, 2'b01);
        ioctl_rom = 1'b0;
        @(negedge clk);
        chk("fall_we", prog_we, 1);
        chk("fall_mask", prog_mask, 2'b01);
        chk("fall_ba", prog_ba, 1);
        chk("fall_addr", prog_addr, 4);
        chk("fall_data", prog_data, 16'hBBBB);
        rdy_pulse();
        chk("fall_idle", {prog_we, dwnld_busy}, 0);

        ioctl_rom = 1'b1;
        @(negedge clk);
        send(26'd4, 8'h12);
        send(26'd8, 8'h34);
        chk("flush_we", prog_we, 1);
        chk("flush_addr", prog_addr, 2);
        chk("flush_mask", prog_mask, 2'b01);
        chk("flush_data", prog_data, 16'h1212);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stable", {prog_we, prog_mask, prog_data, prog_addr[7:0]},
                {1'b1, 2'b01, 16'h1212, 8'h02});
        end
        ioctl_rom = 1'b0;
        rdy_pulse();
        chk("second_we", prog_we, 1);
        chk("second_addr", prog_addr, 4);
        chk("second_data", prog_data, 16'h3434);
        chk("second_mask", prog_mask, 2'b01);
        rdy_pulse();
        chk("second_idle", {prog_we, dwnld_busy}, 0);

        ioctl_rom = 1'b1;
        @(negedge clk);
        send(26'h21, 8'h01);
        chk("ovf_we", prog_we, 1);
        send(26'h40, 8'h02);
        chk("ovf_clear", overflow, 0);
        send(26'h43, 8'h03);
        send(26'h45, 8'h04);
        chk("ovf_set", overflow, 1);
        chk("ovf_slot", {prog_mask, prog_addr}, {2'b10, 22'h10});
        ioctl_rom = 1'b0;
        rdy_pulse();
        chk("ovf_flush", {prog_we, prog_mask, prog_addr},
            {1'b1, 2'b01, 22'h20});
        chk("ovf_fdata", prog_data, 16'h0202);
        rdy_pulse();
        chk("ovf_sticky", {overflow, dwnld_busy}, 2'b10);
        ioctl_rom = 1'b1;
        @(negedge clk);
        chk("ovf_rise", overflow, 0);

        send(26'h51, 8'h05);
        send(26'h60, 8'h06);
        prog_rdy = 1'b1;
        send(26'h62, 8'h07);
        prog_rdy = 1'b0;
        chk("sim_ovf", overflow, 0);
        chk("sim_slot", {prog_we, prog_mask, prog_addr},
            {1'b1, 2'b01, 22'h30});
        chk("sim_data", prog_data, 16'h0606);
        ioctl_rom = 1'b0;
        rdy_pulse();
        chk("sim_next", {prog_we, prog_addr}, {1'b1, 22'h31});
        chk("sim_ndata", prog_data, 16'h0707);
        rdy_pulse();
        chk("sim_idle", dwnld_busy, 0);

        ioctl_rom = 1'b1;
        @(negedge clk);
        send(26'h71, 8'h99);
        chk("prom_sd", {prog_we, prog_addr}, {1'b1, 22'h38});
        send(26'h380003, 8'h5C);
        chk("prom_early", prom_we, 0);
        @(negedge clk);
        chk("prom_pulse", prom_we, 1);
        chk("prom_addr", prog_addr, 3);
        chk("prom_data", prog_data[7:0], 8'h5C);
        chk("prom_keep", prog_we, 1);
        @(negedge clk);
        chk("prom_end", prom_we, 0);
        chk("prom_back", {prog_we, prog_addr}, {1'b1, 22'h38});
        chk("prom_bdata", prog_data, 16'h9999);
        rdy_pulse();
        chk("prom_idle", prog_we, 0);

        send(26'h81, 8'hA1);
        send(26'h90, 8'hB2);
        rst = 1'b1; ioctl_rom = 1'b0;
        @(negedge clk);
        chk("mrst_we", prog_we, 0);
        chk("mrst_mask", prog_mask, 2'b11);
        chk("mrst_bus", {prog_addr, prog_data, prog_ba}, 0);
        chk("mrst_busy", {dwnld_busy, overflow}, 0);
        rst = 1'b0; ioctl_rom = 1'b1;
        @(negedge clk);
        rdy_pulse();
        chk("rdy_ignored", prog_we, 0);
        send(26'h10, 8'hC3);
        send(26'h11, 8'hD4);
        chk("clean_we", prog_we, 1);
        chk("clean_addr", prog_addr, 8);
        chk("clean_data", prog_data, 16'hC3D4);
        chk("clean_mask", prog_mask, 2'b00);
        chk("clean_swab", prog_data1, 16'hD4C3);
        rdy_pulse();
        ioctl_rom = 1'b0;
        @(negedge clk);
        chk("clean_idle", dwnld_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
